// File: rtl/seq_bcd_digit_converter_if.sv
// Bus between the result/display mux and the sequential BCD digit converter.
// The converter is built with or without the LEADING_ZERO_BLANK_EN macro.
//
// Handshake: i_start is sampled on every rising clock edge. It is accepted only
// while o_busy is low (IDLE). Starts seen while busy are dropped, not queued.
// o_done pulses for one cycle on the edge that updates the six digit codes and
// o_overflow. Those outputs hold until the next o_done.
interface seq_bcd_digit_converter_if;
  logic        i_start;
  logic [39:0] i_value;
  logic        i_sign;
  logic        i_err;
  logic        o_busy;
  logic        o_done;
  logic        o_overflow;
  logic [5:0]  o_digit_pos;
  logic [5:0]  o_ten_pos;
  logic [5:0]  o_hundred_pos;
  logic [5:0]  o_thousand_pos;
  logic [5:0]  o_ten_thousand_pos;
  logic [5:0]  o_hundred_thousand_pos;
  logic [1:0]  dbg_state;

  modport master (
    output i_start, i_value, i_sign, i_err,
    input  o_busy, o_done, o_overflow,
    input  o_digit_pos, o_ten_pos, o_hundred_pos,
    input  o_thousand_pos, o_ten_thousand_pos, o_hundred_thousand_pos,
    input  dbg_state
  );

  modport slave (
    input  i_start, i_value, i_sign, i_err,
    output o_busy, o_done, o_overflow,
    output o_digit_pos, o_ten_pos, o_hundred_pos,
    output o_thousand_pos, o_ten_thousand_pos, o_hundred_thousand_pos,
    output dbg_state
  );
endinterface

// File: rtl/seq_bcd_digit_converter.sv
// Sequential double-dabble binary-to-display-code converter with fixed 21-edge latency.
// Optional macro LEADING_ZERO_BLANK_EN: blank leading zeros and float the minus sign.
module seq_bcd_digit_converter #(
  parameter logic [5:0] CODE_E     = 6'd14,
  parameter logic [5:0] CODE_R     = 6'd27,
  parameter logic [5:0] CODE_BLANK = 6'd36,
  parameter logic [5:0] CODE_MINUS = 6'd37
) (
  input logic                     i_clk,
  input logic                     i_rst,
  seq_bcd_digit_converter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] bin_q, bin_d;
  logic [23:0] bcd_q, bcd_d;
  logic [4:0]  step_q, step_d;
  logic        sign_q, sign_d;
  logic        err_q, err_d;
  logic        ovf_q, ovf_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        overflow_q, overflow_d;
  logic [5:0]  pos_q [6];
  logic [5:0]  pos_d [6];

  logic [23:0] bcd_adj;
  logic [43:0] shifted;
  logic [5:0]  fmt [6];
  logic [2:0]  msd;
  logic        nonzero;

  // Add-3 correction on every nibble that would reach 10 or more after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Display formatting of the finished BCD value; index 0 is the 1s position.
  always_comb begin
    msd     = 3'd0;
    nonzero = |bcd_q;
    for (int i = 0; i < 6; i++) begin
      fmt[i] = {2'b00, bcd_q[4*i +: 4]};
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msd = 3'(i);
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 0; i < 6; i++) begin
      if (3'(i) > msd) begin
        fmt[i] = CODE_BLANK;
      end
    end
    // Minus sits just left of the leading digit; negative zero shows no sign.
    if (sign_q && nonzero) begin
      for (int i = 1; i < 6; i++) begin
        if (3'(i) == msd + 3'd1) begin
          fmt[i] = CODE_MINUS;
        end
      end
    end
`else
    if (sign_q && nonzero) begin
      fmt[5] = CODE_MINUS;
    end
`endif
    if (err_q) begin
      fmt[5] = CODE_BLANK;
      fmt[4] = CODE_BLANK;
      fmt[3] = CODE_BLANK;
      fmt[2] = CODE_E;
      fmt[1] = CODE_R;
      fmt[0] = CODE_R;
    end else if (ovf_q) begin
      fmt[5] = CODE_BLANK;
      fmt[4] = CODE_BLANK;
      fmt[3] = CODE_BLANK;
      fmt[2] = CODE_BLANK;
      fmt[1] = CODE_E;
      fmt[0] = CODE_BLANK;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    sign_d     = sign_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    for (int i = 0; i < 6; i++) begin
      pos_d[i] = pos_q[i];
    end

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          bin_d   = bus.i_value[19:0];
          bcd_d   = 24'd0;
          step_d  = 5'd0;
          sign_d  = bus.i_sign;
          err_d   = bus.i_err;
          ovf_d   = (bus.i_value > 40'd999999) ||
                    (bus.i_sign && (bus.i_value > 40'd99999));
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Steps run regardless of err/overflow so the latency never varies.
        bcd_d  = shifted[43:20];
        bin_d  = shifted[19:0];
        step_d = step_q + 5'd1;
        if (step_q == 5'd19) begin
          state_d = FORMAT;
        end
      end
      FORMAT: begin
        for (int i = 0; i < 6; i++) begin
          pos_d[i] = fmt[i];
        end
        overflow_d = ovf_q && !err_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      bin_q      <= 20'd0;
      bcd_q      <= 24'd0;
      step_q     <= 5'd0;
      sign_q     <= 1'b0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        pos_q[i] <= CODE_BLANK;
      end
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      sign_q     <= sign_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      for (int i = 0; i < 6; i++) begin
        pos_q[i] <= pos_d[i];
      end
    end
  end

  assign bus.o_busy                 = busy_q;
  assign bus.o_done                 = done_q;
  assign bus.o_overflow             = overflow_q;
  assign bus.o_digit_pos            = pos_q[0];
  assign bus.o_ten_pos              = pos_q[1];
  assign bus.o_hundred_pos          = pos_q[2];
  assign bus.o_thousand_pos         = pos_q[3];
  assign bus.o_ten_thousand_pos     = pos_q[4];
  assign bus.o_hundred_thousand_pos = pos_q[5];
  assign bus.dbg_state              = state_q;

endmodule

// File: tb/tb_seq_bcd_digit_converter.sv
// Directed self-checking bench for seq_bcd_digit_converter (both macro builds).
module tb_seq_bcd_digit_converter;
  localparam logic [5:0] B = 6'd36;
  localparam logic [5:0] M = 6'd37;
  localparam logic [5:0] E = 6'd14;
  localparam logic [5:0] R = 6'd27;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [35:0] exp_q[$];

  seq_bcd_digit_converter_if bus ();

  seq_bcd_digit_converter dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [35:0] obs_digits;
  assign obs_digits = {bus.o_hundred_thousand_pos, bus.o_ten_thousand_pos,
                       bus.o_thousand_pos, bus.o_hundred_pos,
                       bus.o_ten_pos, bus.o_digit_pos};

  function automatic logic [35:0] pk(input logic [5:0] a, b, c, d, e, f);
    return {a, b, c, d, e, f};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full conversion: drive start, scramble inputs after capture, score done.
  task automatic run_conv(input string tag, input logic [39:0] v, input logic s,
                          input logic e, input logic [35:0] exp_d, input logic exp_ovf);
    int cyc;
    logic [35:0] want;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_value = v;
    bus.i_sign  = s;
    bus.i_err   = e;
    exp_q.push_back(exp_d);
    @(posedge clk);
    #1;
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_value = {8'($urandom), 32'($urandom)};
    bus.i_sign  = 1'($urandom_range(0, 1));
    bus.i_err   = 1'($urandom_range(0, 1));
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_done) break;
    end
    want = exp_q.pop_front();
    if (!bus.o_done) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(cyc), 64'd21);
      check({tag, "_dig"}, 64'(obs_digits), 64'(want));
      check({tag, "_ovf"}, 64'(bus.o_overflow), 64'(exp_ovf));
      check({tag, "_busy_end"}, 64'(bus.o_busy), 64'd0);
      @(posedge clk);
      #1;
      check({tag, "_pulse"}, 64'(bus.o_done), 64'd0);
    end
  endtask

  initial begin
    logic [35:0] held;
    logic        changed;
    int          ndone;
    int          first;
    int          dcyc[$];

    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_value = 40'd0;
    bus.i_sign  = 1'b0;
    bus.i_err   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_ovf", 64'(bus.o_overflow), 64'd0);
    check("rst_dig", 64'(obs_digits), 64'(pk(B, B, B, B, B, B)));
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;

`ifdef LEADING_ZERO_BLANK_EN
    run_conv("zero", 40'd0, 1'b0, 1'b0, pk(B, B, B, B, B, 6'd0), 1'b0);
    run_conv("neg42", 40'd42, 1'b1, 1'b0, pk(B, B, B, M, 6'd4, 6'd2), 1'b0);
    run_conv("neg7", 40'd7, 1'b1, 1'b0, pk(B, B, B, B, M, 6'd7), 1'b0);
    run_conv("negzero", 40'd0, 1'b1, 1'b0, pk(B, B, B, B, B, 6'd0), 1'b0);
`else
    run_conv("zero", 40'd0, 1'b0, 1'b0, pk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0), 1'b0);
    run_conv("neg42", 40'd42, 1'b1, 1'b0, pk(M, 6'd0, 6'd0, 6'd0, 6'd4, 6'd2), 1'b0);
    run_conv("neg7", 40'd7, 1'b1, 1'b0, pk(M, 6'd0, 6'd0, 6'd0, 6'd0, 6'd7), 1'b0);
    run_conv("negzero", 40'd0, 1'b1, 1'b0, pk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0), 1'b0);
`endif
    run_conv("max", 40'd999999, 1'b0, 1'b0, pk(6'd9, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9), 1'b0);
    run_conv("mixed", 40'd987654, 1'b0, 1'b0, pk(6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4), 1'b0);
    run_conv("negmax", 40'd99999, 1'b1, 1'b0, pk(M, 6'd9, 6'd9, 6'd9, 6'd9, 6'd9), 1'b0);
    run_conv("ovf_pos", 40'd1000000, 1'b0, 1'b0, pk(B, B, B, B, E, B), 1'b1);
    run_conv("ovf_neg", 40'd100000, 1'b1, 1'b0, pk(B, B, B, B, E, B), 1'b1);
    run_conv("ovf_hi", 40'h10_0000_0005, 1'b0, 1'b0, pk(B, B, B, B, E, B), 1'b1);
    run_conv("err_ovf", 40'd1000000, 1'b0, 1'b1, pk(B, B, B, E, R, R), 1'b0);
    run_conv("err", 40'd123, 1'b0, 1'b1, pk(B, B, B, E, R, R), 1'b0);

    // Outputs hold through idle cycles.
    held    = obs_digits;
    changed = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (obs_digits !== pk(B, B, B, E, R, R) || bus.o_done || bus.o_overflow) changed = 1'b1;
    end
    check("hold_idle", 64'(changed), 64'd0);

    // Start while busy is ignored.
    ndone = 0;
    first = 0;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      bus.i_start = (i == 0) || (i == 5);
      bus.i_value = (i == 5) ? 40'd7 : 40'd12345;
      bus.i_sign  = 1'b0;
      bus.i_err   = 1'b0;
      @(posedge clk);
      #1;
      if (bus.o_done) begin
        ndone++;
        first = i;
      end
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    check("busy_start_ndone", 64'(ndone), 64'd1);
    check("busy_start_lat", 64'(first), 64'd21);
`ifdef LEADING_ZERO_BLANK_EN
    check("busy_start_dig", 64'(obs_digits), 64'(pk(B, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5)));
`else
    check("busy_start_dig", 64'(obs_digits), 64'(pk(6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5)));
`endif

    // Start held high: back-to-back conversions.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_value = 40'd5;
    for (int i = 1; i <= 70; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done) dcyc.push_back(i);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    check("b2b_count", 64'(dcyc.size()), 64'd3);
    if (dcyc.size() >= 3) begin
      check("b2b_first", 64'(dcyc[0]), 64'd22);
      check("b2b_gap1", 64'(dcyc[1] - dcyc[0]), 64'd22);
      check("b2b_gap2", 64'(dcyc[2] - dcyc[1]), 64'd22);
    end
    for (int i = 0; i < 40 && bus.o_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("b2b_idle", 64'(bus.o_busy), 64'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check("b2b_dig", 64'(obs_digits), 64'(pk(B, B, B, B, B, 6'd5)));
`else
    check("b2b_dig", 64'(obs_digits), 64'(pk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd5)));
`endif

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_value = 40'd555;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    check("mid_rst_done", 64'(bus.o_done), 64'd0);
    check("mid_rst_dig", 64'(obs_digits), 64'(pk(B, B, B, B, B, B)));
    check("mid_rst_state", 64'(bus.dbg_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_done) ndone++;
    end
    check("mid_rst_nodone", 64'(ndone), 64'd0);
`ifdef LEADING_ZERO_BLANK_EN
    run_conv("after_rst", 40'd8, 1'b0, 1'b0, pk(B, B, B, B, B, 6'd8), 1'b0);
`else
    run_conv("after_rst", 40'd8, 1'b0, 1'b0, pk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8), 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
